btn_scan_ctrl: RTL and testbench

Multi-channel push-button scan controller for the board I/O layer. One shared sample-tick prescaler drives N per-channel debounce state machines, replacing one wide free-running counter per switch. Debounced press events go to a round-robin arbiter and are presented one at a time on a valid/ready event port. Downstream logic, such as the LED/7-segment control FSMs, consumes this port.

---
 rtl/btn_scan_pkg.sv | 21 ++
 rtl/btn_db_chan.sv | 77 +++++++
 rtl/btn_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_btn_scan_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_scan_pkg.sv
// -----------------------------------------------------------------------------
// btn_scan_pkg
// Shared definitions for the push-button scan controller:
//   - chan_state_e     : per-channel debounce state (STABLE / SETTLING)
//   - DEFAULT_TICK_DIV : clk cycles per 1 ms sample tick at 50 MHz
//   - evt_id_width()   : width of the event channel index, max(1, $clog2(n))
// -----------------------------------------------------------------------------
package btn_scan_pkg;

  typedef enum logic {
    CH_STABLE   = 1'b0,
    CH_SETTLING = 1'b1
  } chan_state_e;

  localparam int DEFAULT_TICK_DIV = 50000;

  function automatic int evt_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_db_chan.sv
// -----------------------------------------------------------------------------
// btn_db_chan
// One debounce channel: 2-flop synchronizer, saturating disagreement counter
// and debounced level. The counter only moves on the shared sample tick.
//
// Ports:
//   clk_i     in   system clock
//   rst_i     in   synchronous active-high reset
//   btn_i     in   raw asynchronous button input
//   tick_i    in   one-cycle sample tick from the shared prescaler
//   level_o   out  current debounced level (value before any flip this cycle)
//   change_o  out  one-cycle strobe: level flips at the next clock edge
//   state_o   out  debounce state (STABLE when cnt==0, SETTLING otherwise)
// -----------------------------------------------------------------------------
module btn_db_chan
  import btn_scan_pkg::*;
#(
  parameter int STABLE_CNT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_i,
  input  logic        tick_i,
  output logic        level_o,
  output logic        change_o,
  output chan_state_e state_o
);

  localparam int            CW       = $clog2(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          flip;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Any agreeing sample restarts the count, so a bounce shorter than
  // STABLE_CNT ticks never reaches the flip.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    flip    = 1'b0;
    if (tick_i) begin
      if (sync_q2 == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        level_d = ~level_q;
        flip    = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level_o  = level_q;
  assign change_o = flip;
  assign state_o  = (cnt_q == '0) ? CH_STABLE : CH_SETTLING;

endmodule

// File: rtl/btn_scan_ctrl.sv
// -----------------------------------------------------------------------------
// btn_scan_ctrl
// Multi-channel push-button scan controller. One shared prescaler generates the
// sample tick for N debounce channels; press events are held in a one-slot-per-
// channel pending register and issued round-robin on a valid/ready port.
//
// Handshake: evt_valid_o/evt_id_o (and evt_edge_o) stay stable while valid is
// high; the event transfers on a cycle where evt_valid_o && evt_ready_i, after
// which valid is low for at least one cycle.
//
// Build option: define RELEASE_EVT_EN to also report releases; this adds the
// evt_edge_o output (1 = press, 0 = release).
//
// Ports:
//   clk_i          in   system clock
//   rst_i          in   synchronous active-high reset
//   btn_i          in   N raw button inputs
//   level_o        out  N debounced levels
//   evt_valid_o    out  event presented
//   evt_id_o       out  channel of the presented event
//   evt_edge_o     out  event polarity (RELEASE_EVT_EN builds only)
//   evt_ready_i    in   consumer accepts the event
//   ovf_o          out  one-cycle pulse: new event hit a channel still pending
//   dbg_settling_o out  N per-channel debounce state (1 = SETTLING)
// -----------------------------------------------------------------------------
module btn_scan_ctrl
  import btn_scan_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int TICK_DIV   = DEFAULT_TICK_DIV,
  parameter  int STABLE_CNT = 8,
  localparam int IDW        = evt_id_width(N)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   btn_i,
  output logic [N-1:0]   level_o,
  output logic           evt_valid_o,
  output logic [IDW-1:0] evt_id_o,
`ifdef RELEASE_EVT_EN
  output logic           evt_edge_o,
`endif
  input  logic           evt_ready_i,
  output logic           ovf_o,
  output logic [N-1:0]   dbg_settling_o
);

  localparam int             DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);

  // Prescaler
  logic [DW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Debounce channels
  logic [N-1:0] level;
  logic [N-1:0] change;

  for (genvar k = 0; k < N; k++) begin : g_chan
    chan_state_e chan_state;

    btn_db_chan #(
      .STABLE_CNT(STABLE_CNT)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (btn_i[k]),
      .tick_i  (tick),
      .level_o (level[k]),
      .change_o(change[k]),
      .state_o (chan_state)
    );

    assign dbg_settling_o[k] = (chan_state == CH_SETTLING);
  end

  assign level_o = level;

  // Pending events. level is still the pre-flip value during a change strobe,
  // so a press is a change away from 0.
  logic [N-1:0]   set_mask;
  logic [N-1:0]   clr_mask;
  logic [N-1:0]   pend_q;
  logic [N-1:0]   pend_d;
  logic           ovf_d;
  logic           accept;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;

`ifdef RELEASE_EVT_EN
  assign set_mask = change;
`else
  assign set_mask = change & ~level;
`endif

  assign accept = evt_valid_o & evt_ready_i;

  // A set on the channel being accepted wins; it is not an overflow because
  // the old event is leaving this cycle.
  always_comb begin
    clr_mask = '0;
    if (accept) begin
      clr_mask[evt_id_o] = 1'b1;
    end
    pend_d = (pend_q & ~clr_mask) | set_mask;
    ovf_d  = |(set_mask & pend_q & ~clr_mask);
  end

  // Round-robin pick: scanning from the far end down means the last hit is the
  // nearest pending channel after last_grant.
  always_comb begin
    sel  = last_grant_q;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IDW'((int'(last_grant_q) + i) % N);
      if (pend_q[cand]) begin
        sel = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q       <= '0;
      ovf_o        <= 1'b0;
      evt_valid_o  <= 1'b0;
      evt_id_o     <= '0;
      last_grant_q <= ID_LAST;
    end else begin
      pend_q <= pend_d;
      ovf_o  <= ovf_d;
      if (evt_valid_o) begin
        if (evt_ready_i) begin
          evt_valid_o  <= 1'b0;
          last_grant_q <= evt_id_o;
        end
      end else if (|pend_q) begin
        evt_valid_o <= 1'b1;
        evt_id_o    <= sel;
      end
    end
  end

`ifdef RELEASE_EVT_EN
  // Newest polarity per channel; overwrites on overflow.
  logic [N-1:0] pol_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pol_q      <= '0;
      evt_edge_o <= 1'b0;
    end else begin
      pol_q <= (pol_q & ~set_mask) | (set_mask & ~level);
      if (!evt_valid_o && (|pend_q)) begin
        evt_edge_o <= pol_q[sel];
      end
    end
  end
`endif

endmodule

// File: tb/tb_btn_scan_ctrl.sv
`timescale 1ns/1ps
module tb_btn_scan_ctrl;

  localparam int N    = 4;
  localparam int TDIV = 4;
  localparam int SC   = 3;
  localparam int IDW  = 2;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]   btn = '0;
  logic           ready = 1'b1;
  logic [N-1:0]   level_o;
  logic           evt_valid_o;
  logic [IDW-1:0] evt_id_o;
  logic           ovf_o;
  logic [N-1:0]   dbg_settling_o;
`ifdef RELEASE_EVT_EN
  logic           evt_edge_o;
`endif

  btn_scan_ctrl #(
    .N(N), .TICK_DIV(TDIV), .STABLE_CNT(SC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .btn_i         (btn),
    .level_o       (level_o),
    .evt_valid_o   (evt_valid_o),
    .evt_id_o      (evt_id_o),
`ifdef RELEASE_EVT_EN
    .evt_edge_o    (evt_edge_o),
`endif
    .evt_ready_i   (ready),
    .ovf_o         (ovf_o),
    .dbg_settling_o(dbg_settling_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard queues
  logic [IDW-1:0] exp_q[$];
  logic [IDW-1:0] got_q[$];
  int             got_t[$];
  logic           got_e[$];

  // Reference model: counts consecutive disagreeing tick samples per channel
  int           m_cyc;
  logic [N-1:0] m_b1, m_b2, m_s;
  int           m_dis[N];
  logic [N-1:0] m_lvl, m_pend, m_pol, m_old_pend, m_ev, m_evpol;
  logic         m_valid, m_ovf, m_edge, m_tick, m_accept;
  int           m_id, m_last, m_pick;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_cyc = 0; m_b1 = '0; m_b2 = '0; m_lvl = '0; m_pend = '0; m_pol = '0;
      m_valid = 1'b0; m_id = 0; m_last = N - 1; m_ovf = 1'b0; m_edge = 1'b0;
      for (int k = 0; k < N; k++) m_dis[k] = 0;
      exp_q.delete();
    end else begin
      m_s = m_b2; m_b2 = m_b1; m_b1 = btn;
      m_tick = ((m_cyc % TDIV) == TDIV - 1);
      m_cyc++;
      m_accept = m_valid && ready;
      m_ev = '0; m_evpol = '0;
      if (m_tick) begin
        for (int k = 0; k < N; k++) begin
          if (m_s[k] != m_lvl[k]) begin
            m_dis[k]++;
            if (m_dis[k] == SC) begin
              m_dis[k] = 0;
              m_lvl[k] = ~m_lvl[k];
              m_evpol[k] = m_lvl[k];
`ifdef RELEASE_EVT_EN
              m_ev[k] = 1'b1;
`else
              m_ev[k] = m_lvl[k];
`endif
            end
          end else begin
            m_dis[k] = 0;
          end
        end
      end
      m_ovf = 1'b0;
      for (int k = 0; k < N; k++)
        if (m_ev[k] && m_pend[k] && !(m_accept && m_id == k)) m_ovf = 1'b1;
      m_old_pend = m_pend;
      if (m_accept) m_pend[m_id] = 1'b0;
      if (m_valid) begin
        if (ready) begin
          m_valid = 1'b0;
          m_last = m_id;
        end
      end else if (m_old_pend != '0) begin
        m_pick = -1;
        for (int i = 1; i <= N; i++)
          if (m_pick < 0 && m_old_pend[(m_last + i) % N]) m_pick = (m_last + i) % N;
        m_valid = 1'b1;
        m_id = m_pick;
        m_edge = m_pol[m_pick];
        exp_q.push_back(IDW'(m_pick));
      end
      m_pend = m_pend | m_ev;
      m_pol = (m_pol & ~m_ev) | (m_ev & m_evpol);
    end
  end

  // Lockstep monitor and accepted-event scoreboard
  logic [N-1:0]   mon_settle;
  logic [IDW-1:0] mon_exp;

  always @(negedge clk_i) begin
    if (mon_en) begin
      for (int k = 0; k < N; k++) mon_settle[k] = (m_dis[k] != 0);
      checks++;
      if (level_o !== m_lvl) begin
        failures++;
        $display("FAIL model_level t=%0t got=%h exp=%h", $time, level_o, m_lvl);
      end
      checks++;
      if (evt_valid_o !== m_valid) begin
        failures++;
        $display("FAIL model_valid t=%0t got=%b exp=%b", $time, evt_valid_o, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (evt_id_o !== IDW'(m_id)) begin
          failures++;
          $display("FAIL model_id t=%0t got=%0d exp=%0d", $time, evt_id_o, m_id);
        end
`ifdef RELEASE_EVT_EN
        checks++;
        if (evt_edge_o !== m_edge) begin
          failures++;
          $display("FAIL model_edge t=%0t got=%b exp=%b", $time, evt_edge_o, m_edge);
        end
`endif
      end
      checks++;
      if (ovf_o !== m_ovf) begin
        failures++;
        $display("FAIL model_ovf t=%0t got=%b exp=%b", $time, ovf_o, m_ovf);
      end
      checks++;
      if (dbg_settling_o !== mon_settle) begin
        failures++;
        $display("FAIL model_settling t=%0t got=%b exp=%b", $time, dbg_settling_o, mon_settle);
      end
      if (evt_valid_o === 1'b1 && ready && !rst_i) begin
        got_q.push_back(evt_id_o);
        got_t.push_back(cyc);
`ifdef RELEASE_EVT_EN
        got_e.push_back(evt_edge_o);
`else
        got_e.push_back(1'b1);
`endif
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_event t=%0t got_id=%0d exp=none", $time, evt_id_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_exp !== evt_id_o) begin
            failures++;
            $display("FAIL sb_event_id t=%0t got=%0d exp=%0d", $time, evt_id_o, mon_exp);
          end
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the active edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    int lat;
    rst_i = 1'b1; btn = 4'hF; ready = 1'b1;
    step(5);
    mon_en = 1'b1;
    checks++;
    if (level_o !== 4'h0) begin failures++; $display("FAIL reset_level got=%h exp=0", level_o); end
    checks++;
    if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_valid_o); end
    checks++;
    if (evt_id_o !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", evt_id_o); end
    checks++;
    if (ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
    rst_i = 1'b0;
    got_q.delete(); got_t.delete(); got_e.delete();
    lat = 0;
    while (level_o !== 4'hF && lat < 16) begin step(1); lat++; end
    checks++;
    if (level_o !== 4'hF) begin failures++; $display("FAIL reset_level_rise got=%h exp=f", level_o); end
    step(12);
    checks++;
    if (got_q.size() != 4) begin
      failures++; $display("FAIL reset_event_count got=%0d exp=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== IDW'(i)) begin
          failures++; $display("FAIL reset_event_order idx=%0d got=%0d exp=%0d", i, got_q[i], i);
        end
      end
    end
    btn = 4'h0;
    step(30);
  endtask

  task automatic test_bounce();
    logic saw_valid, bad_level;
    saw_valid = 1'b0; bad_level = 1'b0;
    btn = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (evt_valid_o) saw_valid = 1'b1;
      if (level_o !== 4'h0) bad_level = 1'b1;
    end
    btn = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (evt_valid_o) saw_valid = 1'b1;
      if (level_o !== 4'h0) bad_level = 1'b1;
    end
    checks++;
    if (bad_level) begin failures++; $display("FAIL bounce_level got=changed exp=0"); end
    checks++;
    if (saw_valid) begin failures++; $display("FAIL bounce_valid got=1 exp=0"); end
  endtask

  task automatic test_clean_press();
    int lat;
    lat = 0;
    btn = 4'b0100;
    while (level_o[2] !== 1'b1 && lat < 30) begin step(1); lat++; end
    // Counted in clock edges after the drive: the earliest case has a tick
    // right after the synchronizer fills.
    checks++;
    if (lat < 11 || lat > 18) begin
      failures++; $display("FAIL press_latency got=%0d exp=11..18", lat);
    end
    step(1);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd2) begin
      failures++; $display("FAIL press_event got=%b/%0d exp=1/2", evt_valid_o, evt_id_o);
    end
    step(1);
    checks++;
    if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL press_valid_drop got=%b exp=0", evt_valid_o); end
    btn = 4'b0000;
    step(30);
  endtask

  task automatic test_round_robin();
    logic [IDW-1:0] order_a[3];
    logic [IDW-1:0] order_b[3];
    order_a[0] = 2'd0; order_a[1] = 2'd1; order_a[2] = 2'd3;
    order_b[0] = 2'd3; order_b[1] = 2'd0; order_b[2] = 2'd1;
    ready = 1'b1;
    rst_i = 1'b1; step(2); rst_i = 1'b0;
    got_q.delete(); got_t.delete(); got_e.delete();
    btn = 4'b1011;
    step(40);
    checks++;
    if (got_q.size() != 3) begin
      failures++; $display("FAIL rr_a_count got=%0d exp=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== order_a[i]) begin
          failures++; $display("FAIL rr_a_order idx=%0d got=%0d exp=%0d", i, got_q[i], order_a[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (got_t[i] - got_t[i-1] != 2) begin
          failures++; $display("FAIL rr_a_spacing idx=%0d got=%0d exp=2", i, got_t[i] - got_t[i-1]);
        end
      end
    end
    btn = 4'b0000; step(30);
    btn = 4'b0010; step(25);
    btn = 4'b0000; step(30);
    got_q.delete(); got_t.delete(); got_e.delete();
    btn = 4'b1011;
    step(40);
    checks++;
    if (got_q.size() != 3) begin
      failures++; $display("FAIL rr_b_count got=%0d exp=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== order_b[i]) begin
          failures++; $display("FAIL rr_b_order idx=%0d got=%0d exp=%0d", i, got_q[i], order_b[i]);
        end
      end
    end
    btn = 4'b0000; step(30);
  endtask

  task automatic test_backpressure();
    int wait_n, ovf_cnt, exp_ovf;
    logic held_bad;
    ovf_cnt = 0; held_bad = 1'b0; wait_n = 0;
`ifdef RELEASE_EVT_EN
    exp_ovf = 2;
`else
    exp_ovf = 1;
`endif
    ready = 1'b0;
    got_q.delete(); got_t.delete(); got_e.delete();
    btn = 4'b0001;
    while (evt_valid_o !== 1'b1 && wait_n < 30) begin step(1); wait_n++; end
    checks++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd0) begin
      failures++; $display("FAIL bp_first_event got=%b/%0d exp=1/0", evt_valid_o, evt_id_o);
    end
    btn = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (ovf_o) ovf_cnt++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd0) held_bad = 1'b1;
    end
    btn = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (ovf_o) ovf_cnt++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd0) held_bad = 1'b1;
    end
    checks++;
    if (held_bad) begin failures++; $display("FAIL bp_hold got=changed exp=valid1_id0"); end
    checks++;
    if (ovf_cnt != exp_ovf) begin failures++; $display("FAIL bp_ovf_count got=%0d exp=%0d", ovf_cnt, exp_ovf); end
    ready = 1'b1;
    step(10);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL bp_delivered got=%0d exp=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 2'd0) begin failures++; $display("FAIL bp_delivered_id got=%0d exp=0", got_q[0]); end
    end
    checks++;
    if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b exp=0", evt_valid_o); end
    btn = 4'b0000;
    step(30);
  endtask

`ifdef RELEASE_EVT_EN
  task automatic test_release_evt();
    ready = 1'b1;
    got_q.delete(); got_t.delete(); got_e.delete();
    btn = 4'b1000; step(25);
    btn = 4'b0000; step(25);
    checks++;
    if (got_q.size() != 2) begin
      failures++; $display("FAIL rel_count got=%0d exp=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 2'd3 || got_e[0] !== 1'b1) begin
        failures++; $display("FAIL rel_press got=%0d/%b exp=3/1", got_q[0], got_e[0]);
      end
      checks++;
      if (got_q[1] !== 2'd3 || got_e[1] !== 1'b0) begin
        failures++; $display("FAIL rel_release got=%0d/%b exp=3/0", got_q[1], got_e[1]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int hold;
    for (int it = 0; it < 60; it++) begin
      btn = N'($urandom_range(0, 15));
      hold = $urandom_range(1, 20);
      for (int c = 0; c < hold; c++) begin
        ready = ($urandom_range(0, 3) != 0);
        rst_i = ($urandom_range(0, 199) == 0);
        step(1);
      end
    end
    rst_i = 1'b0;
    btn = 4'b0000; ready = 1'b1;
    step(60);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_pending got=%0d exp=0", exp_q.size()); end
    checks++;
    if (evt_valid_o !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", evt_valid_o); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_round_robin();
    test_backpressure();
`ifdef RELEASE_EVT_EN
    test_release_evt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
